// File: rtl/dummy_ro_load_seq_pkg.sv
// Shared types and constants for the dummy ring-oscillator load sequencer.
package dummy_ro_load_seq_pkg;

    localparam int NUM_GROUPS_DEF = 32;
    localparam int LVL_W          = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP,
        ST_HOLD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_RAMP = 2'd0,
        MODE_STEP = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    // Clamp a requested group count to the number of groups actually present.
    function automatic logic [LVL_W-1:0] sat_target(input logic [LVL_W-1:0] t,
                                                    input int unsigned      max_g);
        if (32'(t) > max_g) begin
            return LVL_W'(max_g);
        end
        return t;
    endfunction

endpackage

// File: rtl/dummy_ro_therm_dec.sv
// Level to thermometer select: group g is on whenever level exceeds g.
module dummy_ro_therm_dec
    import dummy_ro_load_seq_pkg::*;
#(
    parameter int NUM_GROUPS = NUM_GROUPS_DEF
) (
    input  logic [LVL_W-1:0]      level_i,
    output logic [NUM_GROUPS-1:0] sel_o
);

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_sel
        assign sel_o[g] = (level_i > LVL_W'(g));
    end

endmodule

// File: rtl/dummy_ro_load_seq.sv
// Dummy RO load sequencer: ramps, holds and drains the number of active
// dummy oscillator groups with a programmable dwell per level step.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | outputs off, waiting for start; latches mode/target/dwell
// ST_RAMP  | level climbing (RAMP/TRIANGLE) or jumping (STEP) to target
// ST_HOLD  | level held at target until stop
// ST_DRAIN | level falling by one every dwell cycles down to zero
// ST_DONE  | single-cycle completion pulse, then back to idle
module dummy_ro_load_seq
    import dummy_ro_load_seq_pkg::*;
#(
    parameter int NUM_GROUPS = NUM_GROUPS_DEF,
    parameter int DWELL_W    = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Start,
    input  logic                  i_Stop,
    input  logic [1:0]            i_Mode,
    input  logic [LVL_W-1:0]      i_Target,
    input  logic [DWELL_W-1:0]    i_Dwell,
    output logic                  o_Enable,
    output logic [NUM_GROUPS-1:0] o_Sel,
    output logic [LVL_W-1:0]      o_Level,
    output logic                  o_Busy,
    output logic                  o_Done
);

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [LVL_W-1:0]   target_q, target_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [LVL_W-1:0]   level_inc;
    logic               step;
    logic               ramp_like;

    // dwell_q is never 0 once a sequence is running, so dwell-1 cannot wrap there
    assign step      = (cnt_q == dwell_q - DWELL_W'(1));
    assign level_inc = level_q + LVL_W'(1);
    assign ramp_like = (mode_q == MODE_RAMP) || (mode_q == MODE_TRI);

    // State, latched configuration, dwell counter and level register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_RAMP;
            target_q <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
        end
    end

    // Next-state, counter and level update; stop wins over a pending step in RAMP
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    mode_d   = mode_t'(i_Mode);
                    target_d = sat_target(i_Target, NUM_GROUPS);
                    dwell_d  = (i_Dwell == '0) ? DWELL_W'(1) : i_Dwell;
                    cnt_d    = '0;
                    level_d  = '0;
                    state_d  = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (i_Stop || (target_q == '0)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else if (ramp_like) begin
                    if (step) begin
                        cnt_d   = '0;
                        level_d = level_inc;
                        if (level_inc == target_q) begin
                            state_d = (mode_q == MODE_TRI) ? ST_DRAIN : ST_HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    level_d = target_q;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_Stop) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (level_q == '0) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (step) begin
                    cnt_d   = '0;
                    level_d = level_q - LVL_W'(1);
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_Enable = (state_q == ST_RAMP) || (state_q == ST_HOLD) || (state_q == ST_DRAIN);
    assign o_Busy   = (state_q != ST_IDLE);
    assign o_Done   = (state_q == ST_DONE);
    assign o_Level  = level_q;

    dummy_ro_therm_dec #(
        .NUM_GROUPS(NUM_GROUPS)
    ) u_therm (
        .level_i(level_q),
        .sel_o  (o_Sel)
    );

endmodule

// File: tb/tb_dummy_ro_load_seq.sv
// Self-checking bench for dummy_ro_load_seq with a phase-level reference model.
module tb_dummy_ro_load_seq;

    localparam int NG = 32;

    logic        clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_Start = 1'b0;
    logic        i_Stop = 1'b0;
    logic [1:0]  i_Mode = 2'd0;
    logic [5:0]  i_Target = 6'd0;
    logic [15:0] i_Dwell = 16'd0;
    logic        o_Enable;
    logic [NG-1:0] o_Sel;
    logic [5:0]  o_Level;
    logic        o_Busy;
    logic        o_Done;

    int vectors = 0;
    int miscompares = 0;

    // expected per-cycle phase (0 idle, 1 ramp, 2 hold, 3 drain, 4 done) and level
    int exp_ph[$];
    int exp_lv[$];

    dummy_ro_load_seq #(.NUM_GROUPS(NG), .DWELL_W(16)) dut (
        .i_Clk   (clk),
        .i_Rst   (i_Rst),
        .i_Start (i_Start),
        .i_Stop  (i_Stop),
        .i_Mode  (i_Mode),
        .i_Target(i_Target),
        .i_Dwell (i_Dwell),
        .o_Enable(o_Enable),
        .o_Sel   (o_Sel),
        .o_Level (o_Level),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] therm(input int l);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NG; i++) r[i] = (i < l);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input int ph, input int lv);
        chk({tag, ":level"},  64'(o_Level),  64'(lv));
        chk({tag, ":sel"},    64'(o_Sel),    therm(lv));
        chk({tag, ":enable"}, 64'(o_Enable), 64'(ph >= 1 && ph <= 3));
        chk({tag, ":busy"},   64'(o_Busy),   64'(ph != 0));
        chk({tag, ":done"},   64'(o_Done),   64'(ph == 4));
    endtask

    task automatic push(input int ph, input int lv);
        exp_ph.push_back(ph);
        exp_lv.push_back(lv);
    endtask

    // Cycle n = n-th cycle after the start is accepted; i_Stop is high only
    // in cycle stop_at while the sequence is ramping or holding.
    task automatic build(input int mode, input int tgt, input int dw, input int stop_at);
        int  t, d, n, lvl;
        bit  stopped, go_hold;
        exp_ph.delete();
        exp_lv.delete();
        t = (tgt > NG) ? NG : tgt;
        d = (dw == 0) ? 1 : dw;
        n = 0;
        stopped = 0;
        lvl = 0;
        go_hold = 0;
        if (t == 0) begin
            push(1, 0);
            n++;
        end else if (mode == 0 || mode == 2) begin
            for (int k = 0; k < t * d; k++) begin
                push(1, k / d);
                if (n == stop_at) begin
                    stopped = 1;
                    lvl = k / d;
                    n++;
                    break;
                end
                n++;
            end
            if (!stopped) lvl = t;
            go_hold = !stopped && (mode == 0);
        end else begin
            push(1, 0);
            if (n == stop_at) begin
                stopped = 1;
                lvl = 0;
            end else begin
                lvl = t;
            end
            n++;
            go_hold = !stopped;
        end
        if (go_hold) begin
            while (n <= stop_at) begin
                push(2, t);
                n++;
            end
        end
        for (int k = 0; k < lvl * d; k++) push(3, lvl - k / d);
        push(3, 0);
        push(4, 0);
        push(0, 0);
        push(0, 0);
    endtask

    task automatic run_seq(input string tag, input int mode, input int tgt, input int dw,
                           input int stop_at, input int rst_at, input bit stop_with_start);
        build(mode, tgt, dw, stop_at);
        @(negedge clk);
        i_Mode   = 2'(mode);
        i_Target = 6'(tgt);
        i_Dwell  = 16'(dw);
        i_Start  = 1'b1;
        i_Stop   = stop_with_start;
        @(posedge clk);
        #1;
        for (int n = 0; n < exp_ph.size(); n++) begin
            check_cycle(tag, exp_ph[n], exp_lv[n]);
            if (n == rst_at) begin
                i_Rst   = 1'b1;
                i_Start = 1'b1;
                i_Stop  = 1'b1;
                @(posedge clk);
                #1;
                i_Rst   = 1'b0;
                i_Start = 1'b0;
                i_Stop  = 1'b0;
                check_cycle({tag, ":after_rst"}, 0, 0);
                return;
            end
            i_Start  = (exp_ph[n] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (exp_ph[n] == 1 || exp_ph[n] == 2) i_Stop = (n == stop_at);
            else i_Stop = 1'($urandom_range(0, 1));
            i_Mode   = 2'($urandom);
            i_Target = 6'($urandom);
            i_Dwell  = 16'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        i_Start = 1'b0;
        i_Stop  = 1'b0;
    endtask

    initial begin
        int mode, tgt, dw, t, d, stop_at;
        i_Rst = 1'b1;
        i_Start = 1'b1;
        i_Stop = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cycle("reset", 0, 0);
        i_Start = 1'b0;
        i_Stop  = 1'b0;
        i_Rst   = 1'b0;
        @(posedge clk);
        #1;
        check_cycle("idle", 0, 0);

        run_seq("ramp_t4_d3", 0, 4, 3, 17, -1, 1'b0);
        run_seq("step_t40_d0", 1, 40, 0, 3, -1, 1'b0);
        run_seq("tri_t2_d1", 2, 2, 1, 100000, -1, 1'b0);
        run_seq("rst_mid_ramp", 0, 20, 2, 100000, 10, 1'b0);
        run_seq("after_rst", 0, 3, 1, 6, -1, 1'b1);
        run_seq("target0", 1, 0, 5, 100000, -1, 1'b0);
        run_seq("target0_tri", 2, 0, 2, 100000, -1, 1'b0);
        run_seq("rsvd_mode", 3, 7, 2, 4, -1, 1'b0);
        run_seq("ramp_stop_early", 0, 10, 3, 7, -1, 1'b0);
        run_seq("step_stop_first", 1, 12, 2, 0, -1, 1'b0);

        for (int it = 0; it < 25; it++) begin
            mode = $urandom_range(0, 3);
            tgt  = $urandom_range(0, 63);
            dw   = $urandom_range(0, 4);
            t = (tgt > NG) ? NG : tgt;
            d = (dw == 0) ? 1 : dw;
            stop_at = $urandom_range(0, t * d + 10);
            run_seq("random", mode, tgt, dw, stop_at, -1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
